// File: rtl/instr_fetch.sv
// Instruction fetch stage: word fetch into a 16-bit parcel buffer,
// RVC/32-bit extraction into the IF/ID register, redirect handling.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        dbg,
    input  logic        mem_hold,
    input  logic        hz,
    input  logic        branch,
    input  logic [31:0] branoff,
    input  logic        trigger_trap,
    input  logic [31:0] trap_addr,
    input  logic        trap_ret,
    input  logic [31:0] ret_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] ins,
    output logic [31:0] IF_ID_pres_addr,
    output logic        comp_sig
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DROP
    } st_e;

    st_e             st_q, st_d;
    logic [3:0][15:0] pbuf_q, pbuf_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     faddr_q, faddr_d;
    logic            skip_q, skip_d;
    logic [31:0]     ins_q, ins_d;
    logic [31:0]     pa_q, pa_d;
    logic            cmp_q, cmp_d;

    logic        adv;
    logic        redir;
    logic [31:0] tgt;
    logic        is32;
    logic        avail;
    logic        take;
    logic        issue;
    logic        append;
    logic [1:0]  idx;

    assign adv    = !dbg && !mem_hold;
    assign redir  = adv && (trigger_trap || trap_ret || branch);
    assign is32   = (pbuf_q[0][1:0] == 2'b11);
    assign avail  = is32 ? (cnt_q >= 3'd2) : (cnt_q >= 3'd1);
    assign take   = adv && !hz && avail && !redir;
    assign issue  = (st_q == S_RUN) && adv && (cnt_q <= 3'd2) && !redir;
    assign append = imem_valid && (st_q == S_WAIT) && !redir;

    always_comb begin
        tgt = branoff;
        if (trigger_trap) begin
            tgt = trap_addr;
        end else if (trap_ret) begin
            tgt = ret_addr;
        end
    end

    // Shift out consumed parcels first, then append at the new tail.
    always_comb begin
        pbuf_d = pbuf_q;
        cnt_d  = cnt_q;
        idx    = 2'd0;
        if (take) begin
            if (is32) begin
                pbuf_d = {32'h0, pbuf_q[3], pbuf_q[2]};
                cnt_d  = cnt_q - 3'd2;
            end else begin
                pbuf_d = {16'h0, pbuf_q[3], pbuf_q[2], pbuf_q[1]};
                cnt_d  = cnt_q - 3'd1;
            end
        end
        if (append) begin
            idx = cnt_d[1:0];
            if (skip_q) begin
                pbuf_d[idx] = imem_rdata[31:16];
                cnt_d       = cnt_d + 3'd1;
            end else begin
                pbuf_d[idx]        = imem_rdata[15:0];
                pbuf_d[idx + 2'd1] = imem_rdata[31:16];
                cnt_d              = cnt_d + 3'd2;
            end
        end
        if (redir) begin
            cnt_d = 3'd0;
        end
    end

    always_comb begin
        st_d    = st_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        skip_d  = skip_q;
        unique case (st_q)
            S_RUN:   if (issue) st_d = S_WAIT;
            S_WAIT: begin
                if (imem_valid) begin
                    st_d = S_RUN;
                end else if (redir) begin
                    st_d = S_DROP;
                end
            end
            S_DROP:  if (imem_valid) st_d = S_RUN;
            default: st_d = S_RUN;
        endcase
        if (redir) begin
            pc_d    = tgt & 32'hFFFF_FFFE;
            faddr_d = tgt & 32'hFFFF_FFFC;
            skip_d  = tgt[1];
        end else begin
            if (take) begin
                pc_d = pc_q + (is32 ? 32'd4 : 32'd2);
            end
            if (issue) begin
                faddr_d = faddr_q + 32'd4;
            end
            if (append) begin
                skip_d = 1'b0;
            end
        end
    end

    always_comb begin
        ins_d = ins_q;
        pa_d  = pa_q;
        cmp_d = cmp_q;
        if (redir || (adv && !hz && !avail)) begin
            ins_d = 32'h0;
            cmp_d = 1'b0;
        end else if (take) begin
            ins_d = is32 ? {pbuf_q[1], pbuf_q[0]} : {16'h0, pbuf_q[0]};
            pa_d  = pc_q;
            cmp_d = !is32;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            st_q    <= S_RUN;
            pbuf_q  <= '0;
            cnt_q   <= 3'd0;
            pc_q    <= RESET_PC;
            faddr_q <= RESET_PC & 32'hFFFF_FFFC;
            skip_q  <= RESET_PC[1];
            ins_q   <= 32'h0;
            pa_q    <= 32'h0;
            cmp_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            pbuf_q  <= pbuf_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            skip_q  <= skip_d;
            ins_q   <= ins_d;
            pa_q    <= pa_d;
            cmp_q   <= cmp_d;
        end
    end

    // Request is combinational so it can leave in the first cycle after reset.
    assign imem_req        = issue && !Rst;
    assign imem_addr       = faddr_q;
    assign ins             = ins_q;
    assign IF_ID_pres_addr = pa_q;
    assign comp_sig        = cmp_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable
// instruction memory responder.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        Rst, dbg, mem_hold, hz, branch, trigger_trap, trap_ret;
    logic [31:0] branoff, trap_addr, ret_addr, imem_rdata;
    logic        imem_valid, imem_req, comp_sig;
    logic [31:0] imem_addr, ins, IF_ID_pres_addr;

    int asserts = 0;
    int fails   = 0;
    int lat     = 1;
    int cyc     = 0;

    logic [31:0] mem [0:255];
    logic [31:0] pq_addr [$];
    int          pq_due  [$];
    logic [31:0] c_ins [$];
    logic [31:0] c_pc  [$];
    logic        c_cmp [$];

    instr_fetch #(.RESET_PC(32'h100)) dut (
        .clk            (clk),
        .Rst            (Rst),
        .dbg            (dbg),
        .mem_hold       (mem_hold),
        .hz             (hz),
        .branch         (branch),
        .branoff        (branoff),
        .trigger_trap   (trigger_trap),
        .trap_addr      (trap_addr),
        .trap_ret       (trap_ret),
        .ret_addr       (ret_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .ins            (ins),
        .IF_ID_pres_addr(IF_ID_pres_addr),
        .comp_sig       (comp_sig)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, expected completion");
        $fatal(1);
    end

    // Memory: one response per request, lat cycles later.
    initial begin
        logic [31:0] a;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!Rst) begin
                asserts++;
                if (dut.cnt_q > 3'd4) begin
                    fails++;
                    $display("FAIL cnt_bound: got %0d expected <= 4", dut.cnt_q);
                end
            end
            if (imem_req) begin
                asserts++;
                if (pq_due.size() != 0 || imem_addr[1:0] != 2'b00) begin
                    fails++;
                    $display("FAIL req_legal: outstanding %0d addr %h expected 0 and aligned",
                             pq_due.size(), imem_addr);
                end
                pq_addr.push_back(imem_addr);
                pq_due.push_back(cyc + lat);
            end
            @(posedge clk);
            #1;
            cyc++;
            imem_valid = 1'b0;
            if (pq_due.size() != 0 && pq_due[0] == cyc) begin
                a = pq_addr.pop_front();
                void'(pq_due.pop_front());
                imem_valid = 1'b1;
                imem_rdata = mem[a[9:2]];
            end
        end
    end

    task automatic redirect(input logic tt, input logic tr, input logic br,
                            input logic [31:0] ta, input logic [31:0] ra,
                            input logic [31:0] bo);
        @(posedge clk);
        #1;
        trigger_trap = tt;
        trap_ret     = tr;
        branch       = br;
        trap_addr    = ta;
        ret_addr     = ra;
        branoff      = bo;
        @(posedge clk);
        #1;
        trigger_trap = 1'b0;
        trap_ret     = 1'b0;
        branch       = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        c_ins.delete();
        c_pc.delete();
        c_cmp.delete();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ins != 32'h0 && c_ins.size() < n) begin
                c_ins.push_back(ins);
                c_pc.push_back(IF_ID_pres_addr);
                c_cmp.push_back(comp_sig);
            end
        end
        while (c_ins.size() < n) begin
            c_ins.push_back(32'hDEAD_BEEF);
            c_pc.push_back(32'hDEAD_BEEF);
            c_cmp.push_back(1'b0);
        end
    endtask

    task automatic wait_req(output logic found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = imem_req;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        asserts++;
        if ({ins, IF_ID_pres_addr, comp_sig} !== 65'h0) begin
            fails++;
            $display("FAIL rst_ifid: got %h/%h/%b expected 0/0/0", ins, IF_ID_pres_addr, comp_sig);
        end
        asserts++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            fails++;
            $display("FAIL rst_req: got %b/%h expected 0/00000100", imem_req, imem_addr);
        end
        @(posedge clk);
        #1;
        Rst = 1'b0;
        @(negedge clk);
        asserts++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            fails++;
            $display("FAIL first_req: got %b/%h expected 1/00000100", imem_req, imem_addr);
        end
        @(negedge clk);
        asserts++;
        if (imem_req !== 1'b0 || ins !== 32'h0) begin
            fails++;
            $display("FAIL cyc1: got req %b ins %h expected 0/0", imem_req, ins);
        end
        @(negedge clk);
        asserts++;
        if (ins !== 32'h0) begin
            fails++;
            $display("FAIL cyc2_ins: got %h expected 0", ins);
        end
        @(negedge clk);
        asserts++;
        if ({ins, IF_ID_pres_addr, comp_sig} !== {32'h00A00093, 32'h100, 1'b0}) begin
            fails++;
            $display("FAIL cyc3_ins: got %h@%h c%b expected 00a00093@00000100 c0",
                     ins, IF_ID_pres_addr, comp_sig);
        end
    endtask

    task automatic test_rvc_stream;
        logic [31:0] ei [3] = '{32'h4581, 32'h4501, 32'h00A00093};
        logic [31:0] ep [3] = '{32'h0, 32'h2, 32'h4};
        logic        ec [3] = '{1'b1, 1'b1, 1'b0};
        mem[0] = 32'h45014581;
        mem[1] = 32'h00A00093;
        mem[2] = 32'h00010001;
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        asserts++;
        if (ins !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL rvc_redir: got ins %h req %b addr %h expected 0/1/0",
                     ins, imem_req, imem_addr);
        end
        collect(3, 20);
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if ({c_ins[i], c_pc[i], c_cmp[i]} !== {ei[i], ep[i], ec[i]}) begin
                fails++;
                $display("FAIL rvc_%0d: got %h@%h c%b expected %h@%h c%b",
                         i, c_ins[i], c_pc[i], c_cmp[i], ei[i], ep[i], ec[i]);
            end
        end
    endtask

    task automatic test_straddle;
        logic [31:0] ei [3] = '{32'h4581, 32'h00A00093, 32'h4501};
        logic [31:0] ep [3] = '{32'h4, 32'h6, 32'hA};
        logic        ec [3] = '{1'b1, 1'b0, 1'b1};
        mem[1] = 32'h00934581;
        mem[2] = 32'h450100A0;
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4);
        collect(3, 20);
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if ({c_ins[i], c_pc[i], c_cmp[i]} !== {ei[i], ep[i], ec[i]}) begin
                fails++;
                $display("FAIL straddle_%0d: got %h@%h c%b expected %h@%h c%b",
                         i, c_ins[i], c_pc[i], c_cmp[i], ei[i], ep[i], ec[i]);
            end
        end
    endtask

    task automatic test_branch_upper;
        logic found;
        mem[128] = 32'h45814501;
        @(posedge clk);
        #1;
        lat = 3;
        wait_req(found);
        asserts++;
        if (!found) begin
            fails++;
            $display("FAIL bu_req_seen: got none expected a request");
        end
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h202);
        @(negedge clk);
        asserts++;
        if (ins !== 32'h0 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL bu_drop: got ins %h req %b expected 0/0", ins, imem_req);
        end
        wait_req(found);
        asserts++;
        if (!found || imem_addr !== 32'h200) begin
            fails++;
            $display("FAIL bu_addr: got %b/%h expected 1/00000200", found, imem_addr);
        end
        collect(1, 20);
        asserts++;
        if ({c_ins[0], c_pc[0], c_cmp[0]} !== {32'h4581, 32'h202, 1'b1}) begin
            fails++;
            $display("FAIL bu_ins: got %h@%h c%b expected 00004581@00000202 c1",
                     c_ins[0], c_pc[0], c_cmp[0]);
        end
    endtask

    task automatic test_priority;
        mem[32]  = 32'h00A00093;
        mem[16]  = 32'h00B00113;
        mem[192] = 32'h45814581;
        @(posedge clk);
        #1;
        lat = 1;
        repeat (6) @(posedge clk);
        redirect(1'b1, 1'b1, 1'b1, 32'h80, 32'h41, 32'h300);
        @(negedge clk);
        asserts++;
        if (ins !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            fails++;
            $display("FAIL prio_trap: got ins %h req %b addr %h expected 0/1/00000080",
                     ins, imem_req, imem_addr);
        end
        collect(1, 15);
        asserts++;
        if ({c_ins[0], c_pc[0], c_cmp[0]} !== {32'h00A00093, 32'h80, 1'b0}) begin
            fails++;
            $display("FAIL prio_trap_ins: got %h@%h c%b expected 00a00093@00000080 c0",
                     c_ins[0], c_pc[0], c_cmp[0]);
        end
        redirect(1'b0, 1'b1, 1'b1, 32'h80, 32'h41, 32'h300);
        @(negedge clk);
        asserts++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            fails++;
            $display("FAIL prio_ret: got req %b addr %h expected 1/00000040", imem_req, imem_addr);
        end
        collect(1, 15);
        asserts++;
        if ({c_ins[0], c_pc[0], c_cmp[0]} !== {32'h00B00113, 32'h40, 1'b0}) begin
            fails++;
            $display("FAIL prio_ret_ins: got %h@%h c%b expected 00b00113@00000040 c0",
                     c_ins[0], c_pc[0], c_cmp[0]);
        end
    endtask

    task automatic test_stall;
        logic [31:0] h_ins, h_pc;
        logic        h_cmp;
        @(posedge clk);
        #1;
        hz = 1'b1;
        @(negedge clk);
        h_ins = ins;
        h_pc  = IF_ID_pres_addr;
        h_cmp = comp_sig;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) hz = 1'b0;
            @(negedge clk);
            asserts++;
            if ({ins, IF_ID_pres_addr, comp_sig} !== {h_ins, h_pc, h_cmp}) begin
                fails++;
                $display("FAIL stall_hold_%0d: got %h@%h expected %h@%h",
                         i, ins, IF_ID_pres_addr, h_ins, h_pc);
            end
        end
        @(negedge clk);
        asserts++;
        if ({ins, IF_ID_pres_addr, comp_sig} !== {32'h1, h_pc + 32'd2, 1'b1}) begin
            fails++;
            $display("FAIL stall_resume: got %h@%h c%b expected 00000001@%h c1",
                     ins, IF_ID_pres_addr, comp_sig, h_pc + 32'd2);
        end
    endtask

    task automatic test_freeze_reset;
        logic        found;
        logic [31:0] a, f_ins, f_pc;
        logic        f_cmp;
        @(posedge clk);
        #1;
        lat = 3;
        wait_req(found);
        a = imem_addr;
        asserts++;
        if (!found) begin
            fails++;
            $display("FAIL frz_req_seen: got none expected a request");
        end
        @(posedge clk);
        #1;
        mem_hold = 1'b1;
        branch   = 1'b1;
        branoff  = 32'h300;
        @(negedge clk);
        f_ins = ins;
        f_pc  = IF_ID_pres_addr;
        f_cmp = comp_sig;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) branch = 1'b0;
            @(negedge clk);
            asserts++;
            if (imem_req !== 1'b0 || {ins, IF_ID_pres_addr, comp_sig} !== {f_ins, f_pc, f_cmp}) begin
                fails++;
                $display("FAIL frz_hold_%0d: got req %b %h@%h expected 0 %h@%h",
                         i, imem_req, ins, IF_ID_pres_addr, f_ins, f_pc);
            end
        end
        @(posedge clk);
        #1;
        mem_hold = 1'b0;
        wait_req(found);
        asserts++;
        if (!found || imem_addr !== a + 32'd4) begin
            fails++;
            $display("FAIL frz_next: got %b/%h expected 1/%h", found, imem_addr, a + 32'd4);
        end
        @(negedge clk);
        Rst = 1'b1;
        #1;
        asserts++;
        if ({ins, IF_ID_pres_addr, comp_sig, imem_req} !== 66'h0 || imem_addr !== 32'h100) begin
            fails++;
            $display("FAIL async_rst: got %h/%h/%b/%b/%h expected 0/0/0/0/00000100",
                     ins, IF_ID_pres_addr, comp_sig, imem_req, imem_addr);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        Rst = 1'b0;
        @(negedge clk);
        asserts++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            fails++;
            $display("FAIL rst_restart: got %b/%h expected 1/00000100", imem_req, imem_addr);
        end
        collect(1, 15);
        asserts++;
        if ({c_ins[0], c_pc[0], c_cmp[0]} !== {32'h00A00093, 32'h100, 1'b0}) begin
            fails++;
            $display("FAIL rst_first_ins: got %h@%h c%b expected 00a00093@00000100 c0",
                     c_ins[0], c_pc[0], c_cmp[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0001_0001;
        mem[64]      = 32'h00A00093;
        Rst          = 1'b1;
        dbg          = 1'b0;
        mem_hold     = 1'b0;
        hz           = 1'b0;
        branch       = 1'b0;
        branoff      = 32'h0;
        trigger_trap = 1'b0;
        trap_addr    = 32'h0;
        trap_ret     = 1'b0;
        ret_addr     = 32'h0;
        test_reset();
        test_rvc_stream();
        test_straddle();
        test_branch_upper();
        test_priority();
        test_stall();
        test_freeze_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
